// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM arbiter
// Purpose: FSM state encoding, default SRAM timing/geometry and port indices.
// Ports: none (package).
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACTIVE = 2'd2,
    END    = 2'd3
  } state_t;

  localparam int DEF_ADDR_W    = 18;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_WR_CYCLES = 2;
  localparam int DEF_RD_CYCLES = 2;

  localparam logic PORT0 = 1'b0;   // record port
  localparam logic PORT1 = 1'b1;   // playback port

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - one requester port of the SRAM arbiter
// Purpose: bundles a requester's request/response handshake.
// Ports (per modport):
//   master: drives req, we, be, addr, wdata; receives ack, rdata
//   slave : receives req, we, be, addr, wdata; drives ack, rdata
interface sram_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              req;
  logic              we;
  logic [1:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, be, addr, wdata, input ack, rdata);
  modport slave  (input req, we, be, addr, wdata, output ack, rdata);

endinterface

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - 2-way grant logic for the SRAM arbiter
// Purpose: picks port 0 or port 1 when the sequencer is idle.
//   Default: round-robin, pointer moves to the non-granted port on each grant.
//   SRAM_ARB_FIXED_PRIO_EN defined: port 0 always wins ties.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req0, req1  port requests
//   advance     high when a grant is actually taken this cycle
//   gnt_valid   at least one request pending
//   gnt_idx     winning port index
module sram_rr_arbiter
  import sram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic gnt_valid,
  output logic gnt_idx
);

  assign gnt_valid = req0 | req1;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  logic unused_rr_inputs;
  assign unused_rr_inputs = clk ^ rst_n ^ advance;

  assign gnt_idx = req0 ? PORT0 : PORT1;
`else
  logic ptr;   // port that wins the next tie

  always_comb begin
    gnt_idx = PORT0;
    if (req0 && req1) begin
      gnt_idx = ptr;
    end else if (req1) begin
      gnt_idx = PORT1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PORT0;
    end else if (advance && gnt_valid) begin
      ptr <= ~gnt_idx;
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter and sequencer for the 256Kx16 async SRAM
// Purpose: shares one SRAM between the record port (p0) and playback port (p1).
//   Every access runs IDLE -> SETUP -> ACTIVE (N cycles) -> END, with all SRAM
//   pins registered. IDLE between accesses is the bus-turnaround cycle.
//   Arbitration mode selected by SRAM_ARB_FIXED_PRIO_EN (see sram_rr_arbiter).
// Ports:
//   CLOCK_50, RESET_N   clock, asynchronous active-low reset
//   p0, p1              requester ports (req/we/be/addr/wdata in, ack/rdata out)
//   SRAM_DQ             bidirectional SRAM data bus
//   SRAM_ADDR           SRAM word address
//   SRAM_*_N            active-low SRAM controls (UB, LB, WE, CE, OE)
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int WR_CYCLES = DEF_WR_CYCLES,
  parameter int RD_CYCLES = DEF_RD_CYCLES
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  sram_arbiter_if.slave     p0,
  sram_arbiter_if.slave     p1,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N
);

  localparam int MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              lat_we_q, lat_we_d;
  logic [1:0]        lat_be_q, lat_be_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              ub_n_q, ub_n_d;
  logic              lb_n_q, lb_n_d;
  logic              dq_oe_q, dq_oe_d;

  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic              gnt_valid, gnt_idx;
  logic              sel_we;
  logic [1:0]        sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  sram_rr_arbiter u_arb (
    .clk       (CLOCK_50),
    .rst_n     (RESET_N),
    .req0      (p0.req),
    .req1      (p1.req),
    .advance   (state_q == IDLE),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign sel_we    = (gnt_idx == PORT1) ? p1.we    : p0.we;
  assign sel_be    = (gnt_idx == PORT1) ? p1.be    : p0.be;
  assign sel_addr  = (gnt_idx == PORT1) ? p1.addr  : p0.addr;
  assign sel_wdata = (gnt_idx == PORT1) ? p1.wdata : p0.wdata;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    lat_we_d    = lat_we_q;
    lat_be_d    = lat_be_q;
    lat_wdata_d = lat_wdata_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    ub_n_d      = 1'b1;
    lb_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          gnt_d       = gnt_idx;
          lat_we_d    = sel_we;
          lat_be_d    = sel_be;
          lat_wdata_d = sel_wdata;
          addr_d      = sel_addr;
          ce_n_d      = 1'b0;
          dq_oe_d     = sel_we;
          // Reads enable both byte lanes regardless of be.
          ub_n_d      = sel_we ? ~sel_be[1] : 1'b0;
          lb_n_d      = sel_we ? ~sel_be[0] : 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        ce_n_d  = 1'b0;
        dq_oe_d = lat_we_q;
        ub_n_d  = lat_we_q ? ~lat_be_q[1] : 1'b0;
        lb_n_d  = lat_we_q ? ~lat_be_q[0] : 1'b0;
        we_n_d  = ~lat_we_q;
        oe_n_d  = lat_we_q;
        cnt_d   = lat_we_q ? CNT_W'(WR_CYCLES - 1) : CNT_W'(RD_CYCLES - 1);
        state_d = ACTIVE;
      end
      ACTIVE: begin
        ce_n_d  = 1'b0;
        dq_oe_d = lat_we_q;   // stays driven through END for data hold
        ub_n_d  = lat_we_q ? ~lat_be_q[1] : 1'b0;
        lb_n_d  = lat_we_q ? ~lat_be_q[0] : 1'b0;
        if (cnt_q == '0) begin
          ack0_d = (gnt_q == PORT0);
          ack1_d = (gnt_q == PORT1);
          if (!lat_we_q) begin
            if (gnt_q == PORT1) begin
              rdata1_d = SRAM_DQ;
            end else begin
              rdata0_d = SRAM_DQ;
            end
          end
          state_d = END;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          we_n_d = ~lat_we_q;
          oe_n_d = lat_we_q;
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      gnt_q       <= PORT0;
      lat_we_q    <= 1'b0;
      lat_be_q    <= '0;
      lat_wdata_q <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      lat_we_q    <= lat_we_d;
      lat_be_q    <= lat_be_d;
      lat_wdata_q <= lat_wdata_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
      dq_oe_q     <= dq_oe_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign SRAM_DQ   = dq_oe_q ? lat_wdata_q : {DATA_W{1'bz}};
  assign SRAM_ADDR = addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = ub_n_q;
  assign SRAM_LB_N = lb_n_q;

  assign p0.ack   = ack0_q;
  assign p1.ack   = ack1_q;
  assign p0.rdata = rdata0_q;
  assign p1.rdata = rdata1_q;

endmodule
